azadi_pad_arbiter: RTL and testbench
====================================

AZADI_PAD_ARBITER -- requirements
Module: azadi_pad_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requesters (0=GPIO, 1=SPI, 2=PWM); legal range 2..4.
REQ-002 SHALL have parameter PAD_W, default 4, number of shared pads.
REQ-003 SHALL have parameter TURN_CYC, default 2, pad turnaround cycles between owners; legal range 1..15.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; port names clk_i and rst_ni.
REQ-005 clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 req_i  input  NUM_REQ  per-requester ownership request, level.
REQ-008 out_i  input  NUM_REQ*PAD_W  per-requester pad output data; requester r occupies bits [r*PAD_W +: PAD_W].
REQ-009 oe_i  input  NUM_REQ*PAD_W  per-requester output enable (active high), packed like out_i.
REQ-010 clr_i  input  1  clears violation_o.
REQ-011 gnt_o  output  NUM_REQ  one-hot-or-zero grant, registered.
REQ-012 pad_out_o  output  PAD_W  data to pads.
REQ-013 pad_oe_o  output  PAD_W  active-high enable to pads; the SoC wrapper inverts it to io_oeb.
REQ-014 owner_o  output  2  index of current owner; valid only while busy_o=1.
REQ-015 busy_o  output  1  high in OWNED state.
REQ-016 violation_o  output  1  sticky flag: a non-granted requester asserted any oe_i bit.

Function
REQ-017 SHALL implement states IDLE, OWNED and TURN.
REQ-018 IDLE: pad_oe_o=0 and pad_out_o=0.
- When any req_i bit is 1, arbitrate and go to OWNED on the next edge.
- gnt_o[winner] SHALL be 1 from that edge; latency is 1 cycle from req_i to gnt_o.
REQ-019 Arbitration SHALL be round-robin: search starts at last_owner+1 modulo NUM_REQ; last_owner resets to NUM_REQ-1, so requester 0 wins first.
REQ-020 OWNED: pad_out_o and pad_oe_o SHALL equal the owner's out_i and oe_i slices, combinationally; all other requesters' slices are ignored.
REQ-021 OWNED: ownership SHALL be held while req_i[owner]=1, regardless of other requests (no preemption).
REQ-022 OWNED with req_i[owner]=0: on the next edge go to TURN, clear gnt_o to 0, load the turn counter with TURN_CYC-1, and set last_owner=owner.
REQ-023 TURN: pad_oe_o=0 and pad_out_o=0 for exactly TURN_CYC cycles.
- The counter decrements each cycle.
- At count 0, the next edge goes to OWNED with a new round-robin grant if any req_i bit is 1, otherwise to IDLE.
REQ-024 Grant-to-grant gap between different owners SHALL be exactly TURN_CYC+1 cycles of gnt_o=0: 1 release cycle, counted from the edge that samples req drop, plus TURN_CYC cycles.
REQ-025 An owner that drops and re-raises req SHALL still pass through TURN, and SHALL lose to any other pending requester because of round-robin.
REQ-026 Requests arriving during TURN SHALL NOT shorten TURN.
REQ-027 Simultaneous multiple requests SHALL yield exactly one grant; gnt_o SHALL never have more than one bit set.
REQ-028 Violation: violation_o SHALL set on the edge after any requester r with gnt_o[r]=0 has oe_i slice != 0.
- It SHALL hold until clr_i=1.
- If clr_i and a new violation occur in the same cycle, set wins.
REQ-029 owner_o SHALL be a registered copy of the owner index, updated on grant; it is 0 after reset.
REQ-030 Request indices >= NUM_REQ do not exist; the arbiter SHALL never select them.

Reset
REQ-031 rst_ni=0 SHALL immediately, without a clock edge, force:
- state=IDLE, gnt_o=0, busy_o=0, owner_o=0;
- violation_o=0, turn counter=0, last_owner=NUM_REQ-1;
- pad_oe_o=0 and pad_out_o=0.
REQ-032 Reset asserted mid-OWNED or mid-TURN SHALL abort without a turnaround. After deassertion, the first arbitration SHALL occur on the first edge that sees req_i!=0.
REQ-033 rst_ni deassertion is synchronized externally; the block does not re-synchronize it.

Verification
REQ-034 Reset, then req_i=3'b110 -> gnt_o=3'b010 one cycle later, busy_o=1, owner_o=1, pads mirror slice 1.
REQ-035 Owner 1 drops req while req_i[2]=1 (TURN_CYC=2) -> gnt_o=0 and pad_oe_o=0 for 3 cycles, then gnt_o=3'b100.
REQ-036 All three requesting continuously, each releasing after 4 cycles then re-requesting -> grant order 0,1,2,0,...; gnt_o never multi-hot.
REQ-037 Owner 0; requester 2 drives oe_i slice=4'hF -> pad_oe_o unaffected, violation_o=1 next cycle. Then clr_i=1 -> violation_o=0.
REQ-038 rst_ni pulsed low during TURN -> all outputs 0 asynchronously. After release with req_i=3'b001 -> gnt_o=3'b001 one cycle later.
REQ-039 TURN_CYC=1, single requester toggling req -> exactly 2 idle cycles between grants; IDLE reached when req_i=0.

Source files
------------

// File: rtl/azadi_pad_arbiter.sv
// azadi_pad_arbiter: round-robin ownership arbiter for shared pads with turnaround and oe-violation flag
module azadi_pad_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int PAD_W    = 4,
  parameter int TURN_CYC = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*PAD_W-1:0] out_i,
  input  logic [NUM_REQ*PAD_W-1:0] oe_i,
  input  logic                     clr_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [PAD_W-1:0]         pad_out_o,
  output logic [PAD_W-1:0]         pad_oe_o,
  output logic [1:0]               owner_o,
  output logic                     busy_o,
  output logic                     violation_o
);
  typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;
  localparam logic [3:0] TURN_LD = 4'(TURN_CYC - 1);
  localparam logic [1:0] LAST_RST = 2'(NUM_REQ - 1);
  state_t               r_state, w_nxt;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt, w_win_oh;
  logic [1:0]           r_owner, w_owner_nxt, r_last, w_last_nxt, w_win;
  logic [3:0]           r_cnt, w_cnt_nxt;
  logic                 r_rel, w_rel_nxt, r_viol, w_viol, w_found, w_own_req;
  logic [PAD_W-1:0]     w_sel_out, w_sel_oe;
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    for (int i = 1; i <= NUM_REQ; i++)
      if (!w_found && req_i[(int'(r_last) + i) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win = 2'((int'(r_last) + i) % NUM_REQ);
      end
  end
  assign w_win_oh = NUM_REQ'(1) << w_win;
  always_comb begin
    w_own_req = 1'b0;
    w_sel_out = '0;
    w_sel_oe = '0;
    w_viol = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (r_owner == 2'(r)) begin
        w_own_req = req_i[r];
        w_sel_out = out_i[r*PAD_W +: PAD_W];
        w_sel_oe = oe_i[r*PAD_W +: PAD_W];
      end
      w_viol = w_viol | (!r_gnt[r] && (|oe_i[r*PAD_W +: PAD_W]));
    end
  end
  // r_rel marks the release cycle that precedes the TURN_CYC counted turnaround cycles
  always_comb begin
    w_nxt = r_state;
    w_gnt_nxt = r_gnt;
    w_owner_nxt = r_owner;
    w_last_nxt = r_last;
    w_cnt_nxt = r_cnt;
    w_rel_nxt = r_rel;
    case (r_state)
      IDLE:
        if (w_found) begin
          w_nxt = OWNED;
          w_gnt_nxt = w_win_oh;
          w_owner_nxt = w_win;
        end
      OWNED:
        if (!w_own_req) begin
          w_nxt = TURN;
          w_gnt_nxt = '0;
          w_cnt_nxt = TURN_LD;
          w_last_nxt = r_owner;
          w_rel_nxt = 1'b1;
        end
      TURN:
        if (r_rel) w_rel_nxt = 1'b0;
        else if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
        else if (w_found) begin
          w_nxt = OWNED;
          w_gnt_nxt = w_win_oh;
          w_owner_nxt = w_win;
        end else w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_owner <= '0;
      r_last <= LAST_RST;
      r_cnt <= '0;
      r_rel <= 1'b0;
      r_viol <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_gnt <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_last <= w_last_nxt;
      r_cnt <= w_cnt_nxt;
      r_rel <= w_rel_nxt;
      r_viol <= w_viol | (r_viol & ~clr_i);
    end
  assign busy_o = (r_state == OWNED);
  assign gnt_o = r_gnt;
  assign owner_o = r_owner;
  assign violation_o = r_viol;
  assign pad_out_o = busy_o ? w_sel_out : '0;
  assign pad_oe_o = busy_o ? w_sel_oe : '0;
endmodule

// File: tb/tb_azadi_pad_arbiter.sv
// tb_azadi_pad_arbiter: directed self-checking bench for the pad arbiter
module tb_azadi_pad_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic [2:0]  req = '0, gnt;
  logic [11:0] out_v = 12'h35A, oe_v = '0;
  logic [3:0]  pad_out, pad_oe;
  logic [1:0]  owner, owner1;
  logic        busy, viol;
  logic [1:0]  req1 = '0, gnt1;
  logic [7:0]  out1 = '0, oe1 = '0;
  logic [3:0]  pad_out1, pad_oe1;
  logic        busy1, viol1;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  azadi_pad_arbiter #(.NUM_REQ(3), .PAD_W(4), .TURN_CYC(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .out_i(out_v), .oe_i(oe_v), .clr_i(clr),
    .gnt_o(gnt), .pad_out_o(pad_out), .pad_oe_o(pad_oe), .owner_o(owner), .busy_o(busy),
    .violation_o(viol));
  azadi_pad_arbiter #(.NUM_REQ(2), .PAD_W(4), .TURN_CYC(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .out_i(out1), .oe_i(oe1), .clr_i(clr),
    .gnt_o(gnt1), .pad_out_o(pad_out1), .pad_oe_o(pad_oe1), .owner_o(owner1), .busy_o(busy1),
    .violation_o(viol1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask
  initial begin
    logic [2:0] o;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pad_oe", 32'(pad_oe), 0);
    chk("rst_pad_out", 32'(pad_out), 0);
    chk("rst_viol", 32'(viol), 0);
    tick;
    rst_n = 1'b1;
    req = 3'b110;
    tick;
    chk("g1_gnt", 32'(gnt), 32'b010);
    chk("g1_busy", 32'(busy), 1);
    chk("g1_owner", 32'(owner), 1);
    chk("g1_pad_out", 32'(pad_out), 32'h5);
    oe_v = 12'h060;
    #1;
    chk("g1_pad_oe", 32'(pad_oe), 32'h6);
    tick;
    chk("hold_gnt", 32'(gnt), 32'b010);
    chk("hold_viol", 32'(viol), 0);
    req = 3'b100;
    oe_v = '0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("turn_gnt", 32'(gnt), 0);
      chk("turn_pad_oe", 32'(pad_oe), 0);
      chk("turn_busy", 32'(busy), 0);
    end
    req = 3'b111;
    tick;
    chk("g2_gnt", 32'(gnt), 32'b100);
    chk("g2_owner", 32'(owner), 2);
    chk("g2_pad_out", 32'(pad_out), 32'h3);
    o = 3'd2;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 3; k++) begin
        tick;
        chk("rr_hold", 32'(gnt), 32'(3'b001 << o));
      end
      req = 3'b111 & ~(3'b001 << o);
      tick;
      chk("rr_gap", 32'(gnt), 0);
      req = 3'b111;
      tick;
      chk("rr_gap", 32'(gnt), 0);
      tick;
      chk("rr_gap", 32'(gnt), 0);
      tick;
      o = (o == 3'd2) ? 3'd0 : o + 3'd1;
      chk("rr_next", 32'(gnt), 32'(3'b001 << o));
    end
    chk("rr_owner0", 32'(owner), 0);
    oe_v = 12'hF00;
    #1;
    chk("v_pad_oe", 32'(pad_oe), 0);
    chk("v_pad_out", 32'(pad_out), 32'hA);
    chk("v_before", 32'(viol), 0);
    tick;
    chk("v_set", 32'(viol), 1);
    oe_v = '0;
    tick;
    chk("v_sticky", 32'(viol), 1);
    clr = 1'b1;
    tick;
    chk("v_clr", 32'(viol), 0);
    oe_v = 12'hF00;
    tick;
    chk("v_set_wins", 32'(viol), 1);
    oe_v = '0;
    tick;
    chk("v_clr2", 32'(viol), 0);
    clr = 1'b0;
    req = 3'b110;
    tick;
    tick;
    tick;
    chk("r_gap", 32'(gnt), 0);
    tick;
    chk("r_gnt1", 32'(gnt), 32'b010);
    req = 3'b100;
    tick;
    chk("r_turn_owner", 32'(owner), 1);
    oe_v = 12'h00F;
    tick;
    chk("r_turn_viol", 32'(viol), 1);
    oe_v = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 0);
    chk("ar_owner", 32'(owner), 0);
    chk("ar_viol", 32'(viol), 0);
    chk("ar_busy", 32'(busy), 0);
    req = 3'b001;
    #1;
    rst_n = 1'b1;
    tick;
    chk("ar_regnt", 32'(gnt), 32'b001);
    chk("ar_pad_out", 32'(pad_out), 32'hA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ao_gnt", 32'(gnt), 0);
    chk("ao_busy", 32'(busy), 0);
    chk("ao_pad_out", 32'(pad_out), 0);
    req = 3'b011;
    #1;
    rst_n = 1'b1;
    tick;
    chk("ao_rr0", 32'(gnt), 32'b001);
    req = 3'b000;
    for (int k = 0; k < 5; k++) tick;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_gnt", 32'(gnt), 0);
    req1 = 2'b01;
    tick;
    chk("t1_gnt", 32'(gnt1), 32'b01);
    req1 = 2'b00;
    tick;
    chk("t1_gap0", 32'(gnt1), 0);
    req1 = 2'b01;
    tick;
    chk("t1_gap1", 32'(gnt1), 0);
    tick;
    chk("t1_regnt", 32'(gnt1), 32'b01);
    req1 = 2'b00;
    for (int k = 0; k < 4; k++) tick;
    chk("t1_idle", 32'(busy1), 0);
    req1 = 2'b10;
    tick;
    chk("t1_idle_gnt", 32'(gnt1), 32'b10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
